conv_window_gen: RTL

- Streaming 3x3 sliding-window generator. It sits directly upstream of the 3x3 convolution core.
- Consumes a raster-order pixel stream for one feature-map channel from the DMA read path and emits one complete 3x3 window per output handshake, stride 1.
- Holds two line buffers plus a 3x3 register array, so each input pixel is fetched from DDR2 exactly once per channel pass.

---
 rtl/conv_window_gen.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator (stride 1) built from two line buffers and a 3x3 register array.
// Define CONV_WINDOW_ZERO_PAD_EN to zero-pad the frame border and emit W*H windows instead of (W-2)*(H-2).
module conv_window_gen #(
  parameter int DATA_W = 32,
  parameter int MAX_W  = 256,
  parameter int DIM_W  = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic [DIM_W-1:0]    cfg_width,
  input  logic [DIM_W-1:0]    cfg_height,
  output logic                cfg_err,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [9*DATA_W-1:0] win_data,
  output logic                win_last
);
`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int LB_D = PAD ? MAX_W + 1 : MAX_W;
  localparam int AW   = $clog2(LB_D);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    w_q, w_d, h_q, h_d, col_q, col_d, row_q, row_d;
  logic [DATA_W-1:0]   arr_q [3][3];
  logic [DATA_W-1:0]   arr_d [3][3];
  logic [9*DATA_W-1:0] win_data_q, win_data_d, win_cand;
  logic                win_valid_q, win_valid_d, win_last_q, win_last_d;
  logic                done_q, done_d, cfg_err_q, cfg_err_d;
  logic [DATA_W-1:0]   lb0_q [LB_D];
  logic [DATA_W-1:0]   lb1_q [LB_D];
  logic [AW-1:0]       lb_addr;
  logic [DATA_W-1:0]   lb0_rd, lb1_rd, pix;
  logic [DIM_W-1:0]    col_end, row_end;
  logic                out_ok, inject, adv, emit, last_pos, cfg_ok;

  assign lb_addr  = col_q[AW-1:0];
  assign lb0_rd   = lb0_q[lb_addr];
  assign lb1_rd   = lb1_q[lb_addr];
  assign out_ok   = !win_valid_q || win_ready;
  // Padding positions (col==W, row==H) advance the stream without consuming input.
  assign inject   = PAD && (col_q == w_q || row_q == h_q);
  assign pix      = inject ? '0 : in_data;
  assign adv      = (state_q == RUN) && out_ok && (inject || in_valid);
  assign col_end  = PAD ? w_q : w_q - DIM_W'(1);
  assign row_end  = PAD ? h_q : h_q - DIM_W'(1);
  assign emit     = PAD ? (row_q >= DIM_W'(1) && col_q >= DIM_W'(1))
                        : (row_q >= DIM_W'(2) && col_q >= DIM_W'(2));
  assign last_pos = (row_q == row_end) && (col_q == col_end);
  assign cfg_ok   = (cfg_width >= DIM_W'(3)) && (cfg_width <= DIM_W'(MAX_W)) &&
                    (cfg_height >= DIM_W'(3));

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      arr_d[r][0] = arr_q[r][1];
      arr_d[r][1] = arr_q[r][2];
    end
    arr_d[0][2] = lb1_rd;
    arr_d[1][2] = lb0_rd;
    arr_d[2][2] = pix;
    win_cand = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        // Top row / left column fall outside the image on the first padded row / column.
        if (!(PAD && ((r == 0 && row_q == DIM_W'(1)) || (c == 0 && col_q == DIM_W'(1)))))
          win_cand[DATA_W*(3*r+c) +: DATA_W] = arr_d[r][c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    win_data_d  = win_data_q;
    win_valid_d = win_valid_q && !win_ready;
    win_last_d  = win_last_q && !(win_valid_q && win_ready);
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_ok) begin
            w_d     = cfg_width;
            h_d     = cfg_height;
            col_d   = '0;
            row_d   = '0;
            state_d = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (adv) begin
          if (col_q == col_end) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          if (emit) begin
            win_data_d  = win_cand;
            win_valid_d = 1'b1;
            win_last_d  = last_pos;
          end
          if (last_pos) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (win_valid_q && win_ready && win_last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          arr_q[r][c] <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_data_q  <= win_data_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      if (adv) arr_q <= arr_d;
    end
  end

  // Line buffers hold no state that matters across frames, so they carry no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      lb1_q[lb_addr] <= lb0_rd;
      lb0_q[lb_addr] <= pix;
    end
  end

  assign in_ready  = (state_q == RUN) && out_ok && !inject;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_last  = win_last_q;

endmodule
